// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI register responder.
package spi_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int RW_BIT    = 7;
   localparam int FRAME_LEN = 8;

endpackage

// File: rtl/spi_reg_responder_if.sv
// SPI pin bundle between an SPI master and the register responder.
interface spi_reg_responder_if;
   import spi_resp_pkg::*;

   logic SCK;
   logic SS;
   logic MOSI;
   logic MISO;

   modport master (output SCK, output SS, output MOSI, input MISO);
   modport slave  (input SCK, input SS, input MOSI, output MISO);

endinterface

// File: rtl/spi_edge_sync.sv
// Synchronizes SCK/SS/MOSI into the PCLK domain and turns SCK transitions
// into sample/shift strobes for the selected CPOL/CPHA mode.
module spi_edge_sync
   import spi_resp_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sck,
   input  logic ss,
   input  logic mosi,
   input  logic cpol,
   input  logic cpha,
   output logic sync_ss,
   output logic sync_mosi,
   output logic sample_edge,
   output logic shift_edge
);

   logic [SYNC_STAGES-1:0] sck_q, sck_d;
   logic [SYNC_STAGES-1:0] ss_q, ss_d;
   logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
   logic                   sck_prev_q, sck_prev_d;
   logic                   sck_s, rise_s, fall_s, lead_s, trail_s;

   // Synchronizer chains and SCK history.
   always_comb begin
      sck_d      = {sck_q[SYNC_STAGES-2:0], sck};
      ss_d       = {ss_q[SYNC_STAGES-2:0], ss};
      mosi_d     = {mosi_q[SYNC_STAGES-2:0], mosi};
      sck_prev_d = sck_q[SYNC_STAGES-1];
   end

   // SS chain resets to the deselected level so release of reset is not a select.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_q      <= '0;
         ss_q       <= '1;
         mosi_q     <= '0;
         sck_prev_q <= 1'b0;
      end else begin
         sck_q      <= sck_d;
         ss_q       <= ss_d;
         mosi_q     <= mosi_d;
         sck_prev_q <= sck_prev_d;
      end
   end

   // Mode-dependent edge classification, suppressed while deselected.
   always_comb begin
      sck_s       = sck_q[SYNC_STAGES-1];
      sync_ss     = ss_q[SYNC_STAGES-1];
      sync_mosi   = mosi_q[SYNC_STAGES-1];
      rise_s      = sck_s & ~sck_prev_q;
      fall_s      = ~sck_s & sck_prev_q;
      lead_s      = cpol ? fall_s : rise_s;
      trail_s     = cpol ? rise_s : fall_s;
      sample_edge = ~sync_ss & (cpha ? trail_s : lead_s);
      shift_edge  = ~sync_ss & (cpha ? lead_s : trail_s);
   end

endmodule

// File: rtl/spi_reg_responder.sv
// SPI slave register bank: command byte (RW + address) followed by one data
// byte; writes commit on the last data bit, reads stream the register out.
module spi_reg_responder
   import spi_resp_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                PCLK,
   input  logic                PRESETn,
   spi_reg_responder_if.slave  spi,
   input  logic                CPOL,
   input  logic                CPHA,
   output logic                WR_PULSE,
   output logic [ADDR_W-1:0]   WR_ADDR,
   output logic [7:0]          WR_DATA,
   input  logic [ADDR_W-1:0]   RD_ADDR,
   output logic [7:0]          RD_DATA,
   output logic                BUSY
);

   localparam int DEPTH = 1 << ADDR_W;

   logic sync_ss, sync_mosi, sample_edge, shift_edge;

   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
      .clk         (PCLK),
      .rst_n       (PRESETn),
      .sck         (spi.SCK),
      .ss          (spi.SS),
      .mosi        (spi.MOSI),
      .cpol        (CPOL),
      .cpha        (CPHA),
      .sync_ss     (sync_ss),
      .sync_mosi   (sync_mosi),
      .sample_edge (sample_edge),
      .shift_edge  (shift_edge)
   );

   state_e            state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        rx_sr_q, rx_sr_d;
   logic [7:0]        tx_sr_q, tx_sr_d;
   logic              load_pending_q, load_pending_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              ss_prev_q, ss_prev_d;
   logic              wr_pulse_q, wr_pulse_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic [7:0]        bank_q [DEPTH];
   logic [7:0]        bank_d [DEPTH];
   logic [7:0]        rx_next_s;
   logic              last_bit_s, ss_fall_s, ss_rise_s;

   // Frame FSM, shift registers and bank update.
   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      rx_sr_d        = rx_sr_q;
      tx_sr_d        = tx_sr_q;
      load_pending_d = load_pending_q;
      rw_d           = rw_q;
      addr_d         = addr_q;
      bank_d         = bank_q;
      wr_pulse_d     = 1'b0;
      wr_addr_d      = wr_addr_q;
      wr_data_d      = wr_data_q;
      ss_prev_d      = sync_ss;
      rx_next_s      = {rx_sr_q[6:0], sync_mosi};
      last_bit_s     = (bit_cnt_q == 3'(FRAME_LEN - 1));
      ss_fall_s      = ss_prev_q & ~sync_ss;
      ss_rise_s      = ~ss_prev_q & sync_ss;

      if (ss_rise_s) begin
         state_d        = IDLE;
         tx_sr_d        = 8'h00;
         load_pending_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ss_fall_s) begin
                  state_d        = CMD;
                  bit_cnt_d      = 3'd0;
                  rx_sr_d        = 8'h00;
                  tx_sr_d        = 8'h00;
                  load_pending_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
            CMD: begin
               if (sample_edge) begin
                  rx_sr_d   = rx_next_s;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (last_bit_s) begin
                     rw_d           = rx_next_s[RW_BIT];
                     addr_d         = rx_next_s[ADDR_W-1:0];
                     load_pending_d = 1'b1;
                     state_d        = DATA;
                  end else begin
                     state_d = CMD;
                  end
               end else begin
                  state_d = CMD;
               end
            end
            DATA: begin
               if (sample_edge) begin
                  rx_sr_d   = rx_next_s;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (last_bit_s) begin
                     state_d        = DONE;
                     tx_sr_d        = 8'h00;
                     load_pending_d = 1'b0;
                     if (!rw_q) begin
                        bank_d[addr_q] = rx_next_s;
                        wr_pulse_d     = 1'b1;
                        wr_addr_d      = addr_q;
                        wr_data_d      = rx_next_s;
                     end else begin
                        wr_pulse_d = 1'b0;
                     end
                  end else begin
                     state_d = DATA;
                  end
               end else begin
                  state_d = DATA;
               end
            end
            DONE: begin
               tx_sr_d = 8'h00;
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         // Shift edges only move MISO data while a byte is in flight.
         if (shift_edge && (state_q == CMD || state_q == DATA)) begin
            if (load_pending_q) begin
               tx_sr_d        = rw_q ? bank_q[addr_q] : 8'h00;
               load_pending_d = 1'b0;
            end else begin
               tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end
         end else begin
            load_pending_d = load_pending_d;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q        <= IDLE;
         bit_cnt_q      <= 3'd0;
         rx_sr_q        <= 8'h00;
         tx_sr_q        <= 8'h00;
         load_pending_q <= 1'b0;
         rw_q           <= 1'b0;
         addr_q         <= '0;
         ss_prev_q      <= 1'b1;
         wr_pulse_q     <= 1'b0;
         wr_addr_q      <= '0;
         wr_data_q      <= 8'h00;
         for (int i = 0; i < DEPTH; i++) bank_q[i] <= 8'h00;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         rx_sr_q        <= rx_sr_d;
         tx_sr_q        <= tx_sr_d;
         load_pending_q <= load_pending_d;
         rw_q           <= rw_d;
         addr_q         <= addr_d;
         ss_prev_q      <= ss_prev_d;
         wr_pulse_q     <= wr_pulse_d;
         wr_addr_q      <= wr_addr_d;
         wr_data_q      <= wr_data_d;
         for (int i = 0; i < DEPTH; i++) bank_q[i] <= bank_d[i];
      end
   end

   assign spi.MISO = tx_sr_q[7] & ~sync_ss;
   assign WR_PULSE = wr_pulse_q;
   assign WR_ADDR  = wr_addr_q;
   assign WR_DATA  = wr_data_q;
   assign RD_DATA  = bank_q[RD_ADDR];
   assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder: bit-banged SPI master with
// scoreboard queues for expected MISO bytes and expected register writes.
module tb_spi_reg_responder;

   localparam int H = 6;

   logic       PCLK;
   logic       PRESETn;
   logic       CPOL, CPHA;
   logic       WR_PULSE;
   logic [3:0] WR_ADDR;
   logic [7:0] WR_DATA;
   logic [3:0] RD_ADDR;
   logic [7:0] RD_DATA;
   logic       BUSY;

   spi_reg_responder_if spi_if ();

   spi_reg_responder #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
      .PCLK     (PCLK),
      .PRESETn  (PRESETn),
      .spi      (spi_if.slave),
      .CPOL     (CPOL),
      .CPHA     (CPHA),
      .WR_PULSE (WR_PULSE),
      .WR_ADDR  (WR_ADDR),
      .WR_DATA  (WR_DATA),
      .RD_ADDR  (RD_ADDR),
      .RD_DATA  (RD_DATA),
      .BUSY     (BUSY)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   int compared = 0;
   int mismatched = 0;

   logic [7:0]  exp_miso [$];
   logic [7:0]  got_miso [$];
   logic [11:0] exp_wr [$];
   logic [11:0] obs_wr [$];

   // Write-commit monitor.
   always @(negedge PCLK) begin
      if (WR_PULSE === 1'b1) obs_wr.push_back({WR_ADDR, WR_DATA});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rd_chk(input logic [3:0] a, input logic [7:0] exp, input string tag);
      RD_ADDR = a;
      #1;
      chk(tag, {24'h0, RD_DATA}, {24'h0, exp});
   endtask

   task automatic set_mode(input int m);
      @(negedge PCLK);
      CPOL       = m[1];
      CPHA       = m[0];
      spi_if.SCK = m[1];
      repeat (6) @(negedge PCLK);
   endtask

   task automatic start_frame;
      @(negedge PCLK);
      spi_if.SS = 1'b0;
      repeat (8) @(negedge PCLK);
      chk("busy_in_frame", {31'h0, BUSY}, 32'd1);
   endtask

   task automatic end_frame;
      repeat (H) @(negedge PCLK);
      spi_if.SS = 1'b1;
      repeat (8) @(negedge PCLK);
      chk("miso_idle", {31'h0, spi_if.MISO}, 32'd0);
      chk("busy_idle", {31'h0, BUSY}, 32'd0);
   endtask

   task automatic xfer(input logic [7:0] tx, input int nbits);
      logic [7:0] rx;
      rx = 8'h00;
      for (int i = 7; i >= 8 - nbits; i--) begin
         if (!CPHA) begin
            spi_if.MOSI = tx[i];
            repeat (H) @(negedge PCLK);
            spi_if.SCK = ~CPOL;
            rx = {rx[6:0], spi_if.MISO};
            repeat (H) @(negedge PCLK);
            spi_if.SCK = CPOL;
         end else begin
            spi_if.SCK  = ~CPOL;
            spi_if.MOSI = tx[i];
            repeat (H) @(negedge PCLK);
            spi_if.SCK = CPOL;
            rx = {rx[6:0], spi_if.MISO};
            repeat (H) @(negedge PCLK);
         end
      end
      if (nbits == 8) got_miso.push_back(rx);
   endtask

   task automatic frame(input logic [7:0] b0, input logic [7:0] b1);
      start_frame();
      xfer(b0, 8);
      xfer(b1, 8);
      end_frame();
   endtask

   task automatic check_miso(input string tag);
      chk({tag, "_miso_count"}, got_miso.size(), exp_miso.size());
      while (got_miso.size() > 0 && exp_miso.size() > 0)
         chk({tag, "_miso"}, {24'h0, got_miso.pop_front()}, {24'h0, exp_miso.pop_front()});
      got_miso.delete();
      exp_miso.delete();
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_wr_count"}, obs_wr.size(), exp_wr.size());
      while (obs_wr.size() > 0 && exp_wr.size() > 0)
         chk({tag, "_wr"}, {20'h0, obs_wr.pop_front()}, {20'h0, exp_wr.pop_front()});
      obs_wr.delete();
      exp_wr.delete();
   endtask

   initial begin
      PRESETn     = 1'b0;
      spi_if.SS   = 1'b1;
      spi_if.SCK  = 1'b0;
      spi_if.MOSI = 1'b0;
      CPOL        = 1'b0;
      CPHA        = 1'b0;
      RD_ADDR     = 4'h0;
      repeat (3) @(negedge PCLK);
      chk("rst_miso", {31'h0, spi_if.MISO}, 32'd0);
      chk("rst_pulse", {31'h0, WR_PULSE}, 32'd0);
      chk("rst_wr_addr", {28'h0, WR_ADDR}, 32'd0);
      chk("rst_wr_data", {24'h0, WR_DATA}, 32'd0);
      chk("rst_busy", {31'h0, BUSY}, 32'd0);
      rd_chk(4'h3, 8'h00, "rst_bank3");
      PRESETn = 1'b1;
      repeat (4) @(negedge PCLK);

      // Mode 0 write then read-back.
      exp_wr.push_back({4'h3, 8'h5A});
      exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
      frame(8'h03, 8'h5A);
      check_miso("m0_write");
      check_writes("m0_write");
      rd_chk(4'h3, 8'h5A, "m0_write_rd");

      exp_miso.push_back(8'h00); exp_miso.push_back(8'h5A);
      frame(8'h83, 8'h00);
      check_miso("m0_read");
      check_writes("m0_read");

      // Every CPOL/CPHA mode: clear, write 0xC3, read back.
      for (int m = 0; m < 4; m++) begin
         set_mode(0);
         exp_wr.push_back({4'hF, 8'h00});
         frame(8'h0F, 8'h00);
         set_mode(m);
         exp_wr.push_back({4'hF, 8'hC3});
         frame(8'h0F, 8'hC3);
         exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
         exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
         exp_miso.push_back(8'h00); exp_miso.push_back(8'hC3);
         frame(8'h8F, 8'h00);
         check_miso($sformatf("mode%0d", m));
         check_writes($sformatf("mode%0d", m));
      end
      set_mode(0);

      // Abort after 5 data bits.
      exp_miso.push_back(8'h00);
      start_frame();
      xfer(8'h02, 8);
      xfer(8'hFF, 5);
      @(negedge PCLK);
      spi_if.SS = 1'b1;
      repeat (3) @(negedge PCLK);
      chk("abort_busy", {31'h0, BUSY}, 32'd0);
      repeat (6) @(negedge PCLK);
      check_miso("abort");
      check_writes("abort");
      rd_chk(4'h2, 8'h00, "abort_rd");

      // Extra third byte is ignored.
      exp_wr.push_back({4'h1, 8'h11});
      exp_miso.push_back(8'h00); exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
      start_frame();
      xfer(8'h01, 8);
      xfer(8'h11, 8);
      xfer(8'hFF, 8);
      end_frame();
      check_miso("extra");
      check_writes("extra");
      rd_chk(4'h1, 8'h11, "extra_rd");

      // Reset during the data byte.
      exp_miso.push_back(8'h00);
      start_frame();
      xfer(8'h04, 8);
      xfer(8'h77, 3);
      @(negedge PCLK);
      PRESETn = 1'b0;
      #1;
      chk("mid_rst_miso", {31'h0, spi_if.MISO}, 32'd0);
      chk("mid_rst_pulse", {31'h0, WR_PULSE}, 32'd0);
      chk("mid_rst_wr_addr", {28'h0, WR_ADDR}, 32'd0);
      chk("mid_rst_wr_data", {24'h0, WR_DATA}, 32'd0);
      chk("mid_rst_busy", {31'h0, BUSY}, 32'd0);
      rd_chk(4'h3, 8'h00, "mid_rst_bank3");
      rd_chk(4'hF, 8'h00, "mid_rst_bankF");
      rd_chk(4'h1, 8'h00, "mid_rst_bank1");
      spi_if.SS  = 1'b1;
      spi_if.SCK = CPOL;
      repeat (4) @(negedge PCLK);
      PRESETn = 1'b1;
      repeat (6) @(negedge PCLK);
      check_miso("mid_rst");
      check_writes("mid_rst");

      exp_wr.push_back({4'h7, 8'hA5});
      exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
      frame(8'h07, 8'hA5);
      exp_miso.push_back(8'h00); exp_miso.push_back(8'hA5);
      frame(8'h87, 8'h00);
      check_miso("post_rst");
      check_writes("post_rst");
      rd_chk(4'h7, 8'hA5, "post_rst_rd");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI slave-side register responder. Makes a bank of 8-bit registers reachable over SPI, so the SoC SPI master can do register read/write transactions in loopback and on board bring-up.
- Runs entirely in the PCLK domain and oversamples the external SCK/SS/MOSI pins.
- The CPU side sees a write-notify pulse and a combinational read port into the bank.

Parameters:
- ADDR_W, 4, register address width; bank depth is 2**ADDR_W.
- SYNC_STAGES, 2, number of synchronizer flops on SCK, SS and MOSI (minimum 2).

Ports:
- PCLK  in  1  system clock.
- PRESETn  in  1  asynchronous active-low reset.
- SCK  in  1  SPI clock from the master.
- SS  in  1  slave select, active low.
- MOSI  in  1  serial data from the master.
- MISO  out  1  serial data to the master; 0 when SS is high (no tristate).
- CPOL  in  1  clock idle polarity.
- CPHA  in  1  clock phase.
- WR_PULSE  out  1  one-cycle pulse when an SPI write commits.
- WR_ADDR  out  ADDR_W  address of the last committed write.
- WR_DATA  out  8  data of the last committed write.
- RD_ADDR  in  ADDR_W  local read address.
- RD_DATA  out  8  combinational read, reg[RD_ADDR].
- BUSY  out  1  1 while a transaction is active (FSM not in IDLE).

Behaviour:
- Clocking and reset:
  - One clock, PCLK. Reset is asynchronous and active-low on PRESETn.
  - Reset clears every register, all FSM state and all outputs: MISO=0, WR_PULSE=0, WR_ADDR=0, WR_DATA=0, BUSY=0, all bank entries 0x00.
- Input conditioning:
  - SCK, SS and MOSI each pass through SYNC_STAGES flops. An edge detector on the synchronized SCK adds one further flop.
  - Constraint: SCK high and low phases must each be ≥4 PCLK cycles.
- Edge selection:
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1.
  - Shift edge = the other edge.
  - Edges are ignored while synchronized SS=1.
- Frame format, MSB first:
  - Byte 0 is the command: bit7 = RW (1 = read), bits[ADDR_W-1:0] = address, remaining bits ignored.
  - Byte 1 is the data byte.
- FSM states: IDLE, CMD, DATA, DONE.
  - IDLE → CMD on synchronized SS falling. Clears bit counter, rx shift register and tx_sr.
  - CMD: rx_sr <= {rx_sr[6:0], MOSI} on each sample edge. On the 8th sample edge, latch RW and address, set load_pending, go to DATA.
  - DATA, read (RW=1): rx bits are ignored. Go to DONE on the 8th sample edge.
  - DATA, write (RW=0): on the 8th sample edge, write reg[addr] <= assembled byte. In the same cycle WR_PULSE=1 and WR_ADDR/WR_DATA update. Go to DONE.
  - DONE: all further SCK edges are ignored. MISO holds 0.
  - Any state → IDLE on synchronized SS rising. An incomplete command or data byte is discarded: no write, no pulse.
- MISO generation:
  - MISO = tx_sr[7] while SS is low.
  - On each shift edge: if load_pending, then tx_sr <= reg[addr] (read) or 0x00 (write) and load_pending is cleared; otherwise tx_sr <= tx_sr<<1.
  - With CPHA=0 this puts the MSB out after the trailing edge of command bit 8. With CPHA=1 it puts the MSB out at the leading edge of data bit 1.
- Read-data timing: the read data is the register value at the load shift edge. A local-side conflict cannot occur because the bank has no local write port.
- BUSY = 1 in CMD, DATA and DONE.

Decomposition:
- Shared package spi_resp_pkg holds:
  - the state enum: IDLE, CMD, DATA, DONE;
  - the RW bit index constant: 7;
  - the frame length constant: 8.
- One natural sub-module, spi_edge_sync: the synchronizer chain plus edge detector. It outputs sync_ss, sync_mosi, sample_edge and shift_edge given CPOL/CPHA.

Test Plan:
- Mode 0 write: SS low, send 0x03 then 0x5A, SS high → one WR_PULSE with WR_ADDR=3, WR_DATA=0x5A; RD_ADDR=3 gives RD_DATA=0x5A.
- Mode 0 read-back: after the write, send 0x83 then 0x00 → MISO byte 1 = 0x5A, MISO byte 0 = 0x00, no WR_PULSE.
- All four CPOL/CPHA modes: write 0xC3 to addr 0xF, then read it back → master receives 0xC3 in every mode.
- Abort: SS raised after 5 bits of the data byte of a write to addr 2 → no WR_PULSE, reg[2] unchanged (0x00), BUSY=0 two-to-three cycles after SS rises.
- Extra bytes: write frame 0x01, 0x11, then a third byte 0xFF → exactly one pulse, reg[1]=0x11, MISO=0 during byte 2.
- Reset mid-transaction: assert PRESETn low during the data byte → all outputs 0 immediately, bank cleared; the next full frame after reset works normally.
